// File: rtl/renderer_pkg.sv
// renderer_pkg: shared types, colours and widths for the spectrum bar renderer.
`default_nettype none

package renderer_pkg;

  localparam int HEIGHT_W = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [23:0] COL_BLACK  = 24'h000000;
  localparam logic [23:0] COL_GREEN  = 24'h00FF00;
  localparam logic [23:0] COL_YELLOW = 24'hFFFF00;
  localparam logic [23:0] COL_RED    = 24'hFF0000;
  localparam logic [23:0] COL_WHITE  = 24'hFFFFFF;

endpackage

`default_nettype wire

// File: rtl/spectrum_log2.sv
// spectrum_log2: priority encoder giving floor(log2) of an unsigned magnitude plus a zero flag.
`default_nettype none

module spectrum_log2 #(
  parameter int DATA_W = 16,
  parameter int LOG_W  = 4
) (
  input  logic [DATA_W-1:0] i_value,
  output logic [LOG_W-1:0]  o_log2,
  output logic              o_zero
);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    o_log2 = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i_value[i]) o_log2 = LOG_W'(i);
    end
  end

  assign o_zero = (i_value == '0);

endmodule

`default_nettype wire

// File: rtl/spectrum_bar_renderer.sv
// spectrum_bar_renderer: captures FFT frames, converts bins to log bar heights with peak hold
// during vertical blanking, and paints the bars with a 2-cycle registered pixel path.
`default_nettype none

module spectrum_bar_renderer
  import renderer_pkg::*;
#(
  parameter int N_BINS      = 16,
  parameter int DATA_W      = 16,
  parameter int BAR_W_LOG2  = 5,
  parameter int SCREEN_H    = 480,
  parameter int LOG_SHIFT   = 4,
  parameter int HOLD_FRAMES = 8,
  parameter int DECAY_STEP  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_BINS-1:0][DATA_W-1:0]  i_fft_data,
  input  logic                           i_fft_valid,
  input  logic                           i_frame_start,
  input  logic [10:0]                    i_VGA_X,
  input  logic [10:0]                    i_VGA_Y,
  output logic [7:0]                     o_VGA_R,
  output logic [7:0]                     o_VGA_G,
  output logic [7:0]                     o_VGA_B,
  output logic                           o_busy,
  output logic                           o_overrun
);

  localparam int K_W    = $clog2(N_BINS);
  localparam int LOG_W  = $clog2(DATA_W);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int AREA_W = N_BINS << BAR_W_LOG2;

  state_t               r_state, w_next;
  logic [DATA_W-1:0]    r_shadow [N_BINS];
  logic [DATA_W-1:0]    r_work   [N_BINS];
  logic                 r_pending;
  logic [K_W-1:0]       r_k;
  logic                 r_overrun;
  logic [HEIGHT_W-1:0]  r_height [N_BINS];
  logic [HEIGHT_W-1:0]  r_peak   [N_BINS];
  logic [HOLD_W-1:0]    r_hold   [N_BINS];

  logic                 w_start;
  logic [DATA_W-1:0]    w_cur, w_abs;
  logic [LOG_W-1:0]     w_log2;
  logic                 w_zero;
  logic [31:0]          w_h_full;
  logic [HEIGHT_W-1:0]  w_h;

  assign w_start = (r_state == IDLE) && i_frame_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (i_frame_start) w_next = LATCH;
      LATCH:   w_next = UPDATE;
      UPDATE:  if (r_k == K_W'(N_BINS - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The shadow->work copy is taken on the frame_start edge itself, so a strobe in that
  // same cycle lands in the shadow buffer and stays pending for the following frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      r_k       <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < N_BINS; i++) begin
        r_shadow[i] <= '0;
        r_work[i]   <= '0;
      end
    end else begin
      r_overrun <= i_frame_start && (r_state != IDLE);
      r_k       <= (r_state == UPDATE) ? r_k + K_W'(1) : '0;
      if (w_start && r_pending) begin
        for (int i = 0; i < N_BINS; i++) r_work[i] <= r_shadow[i];
      end
      if (i_fft_valid) begin
        for (int i = 0; i < N_BINS; i++) r_shadow[i] <= i_fft_data[i];
        r_pending <= 1'b1;
      end else if (w_start) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Two's-complement magnitude; the most negative value wraps to 2^(DATA_W-1) unsigned.
  assign w_cur    = r_work[r_k];
  assign w_abs    = w_cur[DATA_W-1] ? (~w_cur + DATA_W'(1)) : w_cur;
  assign w_h_full = (32'(w_log2) + 32'd1) << LOG_SHIFT;
  assign w_h      = w_zero ? '0 :
                    (w_h_full > 32'(SCREEN_H)) ? HEIGHT_W'(SCREEN_H) : w_h_full[HEIGHT_W-1:0];

  spectrum_log2 #(
    .DATA_W (DATA_W),
    .LOG_W  (LOG_W)
  ) u_log2 (
    .i_value (w_abs),
    .o_log2  (w_log2),
    .o_zero  (w_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_BINS; i++) begin
        r_height[i] <= '0;
        r_peak[i]   <= '0;
        r_hold[i]   <= '0;
      end
    end else if (r_state == UPDATE) begin
      r_height[r_k] <= w_h;
      if (w_h >= r_peak[r_k]) begin
        r_peak[r_k] <= w_h;
        r_hold[r_k] <= HOLD_W'(HOLD_FRAMES);
      end else if (r_hold[r_k] != '0) begin
        r_hold[r_k] <= r_hold[r_k] - HOLD_W'(1);
      end else if (32'(r_peak[r_k]) > 32'(w_h) + 32'(DECAY_STEP)) begin
        r_peak[r_k] <= r_peak[r_k] - HEIGHT_W'(DECAY_STEP);
      end else begin
        r_peak[r_k] <= w_h;
      end
    end
  end

  logic [K_W-1:0]       r_bin;
  logic [HEIGHT_W-1:0]  r_row;
  logic                 r_in_area, r_sep;
  logic [HEIGHT_W-1:0]  w_pk, w_ht;
  logic [23:0]          w_col, r_rgb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin     <= '0;
      r_row     <= '0;
      r_in_area <= 1'b0;
      r_sep     <= 1'b0;
      r_rgb     <= COL_BLACK;
    end else begin
      r_bin     <= i_VGA_X[BAR_W_LOG2 +: K_W];
      r_row     <= HEIGHT_W'(SCREEN_H - 1) - i_VGA_Y;
      r_in_area <= (32'(i_VGA_X) < 32'(AREA_W)) && (32'(i_VGA_Y) < 32'(SCREEN_H));
      r_sep     <= &i_VGA_X[BAR_W_LOG2-1:0];
      r_rgb     <= w_col;
    end
  end

  assign w_pk = r_peak[r_bin];
  assign w_ht = r_height[r_bin];

  always_comb begin
    w_col = COL_BLACK;
    if (!r_in_area || r_sep) begin
      w_col = COL_BLACK;
    end else if (w_pk >= HEIGHT_W'(2) &&
                 (r_row == w_pk - HEIGHT_W'(2) || r_row == w_pk - HEIGHT_W'(1))) begin
      w_col = COL_WHITE;
    end else if (r_row < w_ht) begin
      if (r_row < HEIGHT_W'(SCREEN_H / 2))          w_col = COL_GREEN;
      else if (r_row < HEIGHT_W'(3 * SCREEN_H / 4)) w_col = COL_YELLOW;
      else                                          w_col = COL_RED;
    end
  end

  assign o_VGA_R   = r_rgb[23:16];
  assign o_VGA_G   = r_rgb[15:8];
  assign o_VGA_B   = r_rgb[7:0];
  assign o_busy    = (r_state != IDLE);
  assign o_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_spectrum_bar_renderer.sv
// tb_spectrum_bar_renderer: table vectors, directed handshake sequences and randomized frames
// checked against an arithmetic model of heights, peaks and pixel colours.
`default_nettype none

module tb_spectrum_bar_renderer;

  localparam int N = 16;
  localparam logic [23:0] K = 24'h000000, G = 24'h00FF00, Y = 24'hFFFF00;
  localparam logic [23:0] R = 24'hFF0000, W = 24'hFFFFFF;

  logic              clk = 1'b0, rst = 1'b1;
  logic [N-1:0][15:0] fft_data = '0;
  logic              fft_valid = 1'b0, frame_start = 1'b0;
  logic [10:0]       vx = '0, vy = '0;
  logic [7:0]        r_o, g_o, b_o, sr, sg, sb;
  logic              busy, overrun, s_busy, s_overrun;

  int total = 0, bad = 0;

  // Model state
  int m_shadow[N], m_work[N], m_height[N], m_peak[N], m_hold[N];
  bit m_pending;

  always #5 clk = ~clk;

  spectrum_bar_renderer dut (
    .i_clk(clk), .i_rst(rst), .i_fft_data(fft_data), .i_fft_valid(fft_valid),
    .i_frame_start(frame_start), .i_VGA_X(vx), .i_VGA_Y(vy),
    .o_VGA_R(r_o), .o_VGA_G(g_o), .o_VGA_B(b_o), .o_busy(busy), .o_overrun(overrun)
  );

  spectrum_bar_renderer #(.LOG_SHIFT(5)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_fft_data(fft_data), .i_fft_valid(fft_valid),
    .i_frame_start(frame_start), .i_VGA_X(vx), .i_VGA_Y(vy),
    .o_VGA_R(sr), .o_VGA_G(sg), .o_VGA_B(sb), .o_busy(s_busy), .o_overrun(s_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic int model_h(input int v, input int shift);
    int s, a, l;
    s = int'($signed(16'(v)));
    a = (s < 0) ? -s : s;
    if (a == 0) return 0;
    l = 0;
    while (a > 1) begin a = a / 2; l++; end
    return ((l + 1) * (1 << shift) > 480) ? 480 : (l + 1) * (1 << shift);
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < N; b++) begin
      m_shadow[b] = 0; m_work[b] = 0; m_height[b] = 0; m_peak[b] = 0; m_hold[b] = 0;
    end
    m_pending = 0;
  endfunction

  function automatic void model_capture();
    for (int b = 0; b < N; b++) m_shadow[b] = int'(fft_data[b]);
    m_pending = 1;
  endfunction

  function automatic void model_frame();
    int h;
    if (m_pending) begin
      m_work = m_shadow;
      m_pending = 0;
    end
    for (int b = 0; b < N; b++) begin
      h = model_h(m_work[b], 4);
      m_height[b] = h;
      if (h >= m_peak[b]) begin
        m_peak[b] = h; m_hold[b] = 8;
      end else if (m_hold[b] > 0) begin
        m_hold[b]--;
      end else begin
        m_peak[b] = (m_peak[b] - 4 > h) ? m_peak[b] - 4 : h;
      end
    end
  endfunction

  function automatic logic [23:0] exp_rgb(input int x, input int y);
    int bin, row, pk;
    if (x >= N * 32 || y >= 480) return K;
    if (x % 32 == 31) return K;
    bin = x / 32; row = 479 - y; pk = m_peak[bin];
    if (pk >= 2 && (row == pk - 2 || row == pk - 1)) return W;
    if (row < m_height[bin]) return (row < 240) ? G : (row < 360) ? Y : R;
    return K;
  endfunction

  task automatic set_pix(input int x, input int y);
    vx = 11'(x); vy = 11'(y);
    cyc(); cyc();
  endtask

  task automatic check_pix(input int x, input int y, input string nm);
    logic [23:0] e;
    e = exp_rgb(x, y);
    set_pix(x, y);
    chk(nm, {8'h0, r_o, g_o, b_o}, {8'h0, e});
  endtask

  task automatic strobe();
    fft_valid = 1'b1; cyc(); fft_valid = 1'b0;
    model_capture();
  endtask

  // Pulses frame_start (optionally with a coincident strobe) and checks the busy window length.
  task automatic frame(input bit with_valid);
    int n;
    frame_start = 1'b1; fft_valid = with_valid;
    cyc();
    frame_start = 1'b0; fft_valid = 1'b0;
    model_frame();
    if (with_valid) model_capture();
    chk("overrun_idle", 32'(overrun), 0);
    n = 0;
    while (busy && n < 64) begin n++; cyc(); end
    chk("busy_len", n, N + 1);
  endtask

  typedef struct { int x; int y; logic [23:0] rgb; } vec_t;
  vec_t vt[18];

  initial begin
    vt[0]  = '{10, 479, G}; vt[1]  = '{10, 338, G}; vt[2]  = '{10, 337, W};
    vt[3]  = '{10, 336, W}; vt[4]  = '{10, 335, K}; vt[5]  = '{40, 239, Y};
    vt[6]  = '{40, 226, Y}; vt[7]  = '{40, 225, W}; vt[8]  = '{40, 224, W};
    vt[9]  = '{40, 223, K}; vt[10] = '{70, 466, G}; vt[11] = '{70, 465, W};
    vt[12] = '{70, 463, K}; vt[13] = '{100, 479, K}; vt[14] = '{31, 479, K};
    vt[15] = '{512, 479, K}; vt[16] = '{10, 480, K}; vt[17] = '{40, 479, G};

    model_reset();
    vx = 11'd10; vy = 11'd479;
    repeat (3) cyc();
    chk("reset_rgb", {8'h0, r_o, g_o, b_o}, 0);
    chk("reset_busy", {busy, overrun}, 0);
    rst = 1'b0;
    check_pix(10, 479, "post_reset_black");

    // Test-plan frame
    fft_data = '0;
    fft_data[0] = 16'h0100; fft_data[1] = 16'h8000; fft_data[2] = 16'hFFFF; fft_data[3] = 16'h0000;
    strobe();
    frame(1'b0);
    for (int i = 0; i < 18; i++) begin
      set_pix(vt[i].x, vt[i].y);
      chk($sformatf("vec%0d", i), {8'h0, r_o, g_o, b_o}, {8'h0, vt[i].rgb});
    end

    // Peak hold then decay on bin 0
    fft_data = '0; fft_data[0] = 16'h0100;
    strobe(); frame(1'b0);
    fft_data = '0;
    strobe();
    for (int f = 1; f <= 46; f++) begin
      frame(1'b0);
      if (f == 8) begin set_pix(10, 336); chk("hold8_peak144", {8'h0, r_o, g_o, b_o}, {8'h0, W}); end
      if (f == 9) begin
        set_pix(10, 340); chk("decay_peak140", {8'h0, r_o, g_o, b_o}, {8'h0, W});
        set_pix(10, 336); chk("decay_old_gone", {8'h0, r_o, g_o, b_o}, {8'h0, K});
      end
      if (m_peak[0] >= 2) begin
        check_pix(10, 479 - (m_peak[0] - 1), "decay_mark");
        check_pix(10, 479 - m_peak[0], "decay_above");
      end else begin
        check_pix(10, 479, "decay_zero");
      end
    end
    set_pix(10, 479); chk("no_wrap_row0", {8'h0, r_o, g_o, b_o}, {8'h0, K});
    set_pix(10, 1);   chk("no_wrap_top", {8'h0, r_o, g_o, b_o}, {8'h0, K});

    // Saturation on the LOG_SHIFT=5 instance
    fft_data = '0; fft_data[0] = 16'h8000;
    strobe(); frame(1'b0);
    set_pix(10, 0); chk("sat_row479_white", {8'h0, sr, sg, sb}, {8'h0, W});
    set_pix(10, 2); chk("sat_row477_red", {8'h0, sr, sg, sb}, {8'h0, R});
    set_pix(10, 100); chk("sat_row379_red", {8'h0, sr, sg, sb}, {8'h0, R});
    check_pix(10, 224, "main_0x8000");

    // Strobe coincident with frame_start
    fft_data = '0; fft_data[0] = 16'h0010;
    strobe(); frame(1'b0);
    fft_data[0] = 16'h4000;
    frame(1'b1);
    set_pix(10, 399); chk("coinc_old_data", {8'h0, r_o, g_o, b_o}, {8'h0, K});
    check_pix(10, 400, "coinc_model");
    frame(1'b0);
    set_pix(10, 399); chk("coinc_new_data", {8'h0, r_o, g_o, b_o}, {8'h0, G});
    check_pix(10, 240, "coinc_top");

    // frame_start during UPDATE
    begin
      int n;
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      model_frame();
      n = 0;
      repeat (2) begin n += int'(busy); cyc(); end
      frame_start = 1'b1; n += int'(busy); cyc(); frame_start = 1'b0;
      chk("overrun_pulse", 32'(overrun), 1);
      n += int'(busy); cyc();
      chk("overrun_one_cycle", 32'(overrun), 0);
      while (busy && n < 64) begin n++; cyc(); end
      chk("overrun_no_restart", n, N + 1);
      check_pix(10, 400, "after_overrun");
    end

    // Randomized frames
    for (int it = 0; it < 10; it++) begin
      for (int b = 0; b < N; b++) begin
        logic [15:0] v;
        v = 16'($urandom) >> $urandom_range(0, 16);
        if ($urandom_range(0, 1) == 1) v = -v;
        if ($urandom_range(0, 15) == 0) v = 16'h8000;
        fft_data[b] = v;
      end
      if ($urandom_range(0, 3) != 0) strobe();
      frame(1'b0);
      for (int b = 0; b < N; b++) begin
        int rows[4];
        rows[0] = m_height[b] - 1; rows[1] = m_height[b];
        rows[2] = m_peak[b] - 1;   rows[3] = m_peak[b] - 3;
        for (int j = 0; j < 4; j++)
          if (rows[j] >= 0 && rows[j] < 480) check_pix(b * 32 + 5, 479 - rows[j], "rand_edge");
      end
      for (int j = 0; j < 8; j++)
        check_pix($urandom_range(0, N * 32 + 40), $urandom_range(0, 490), "rand_pix");
    end

    // Reset during UPDATE, with a pending frame that must be discarded
    fft_data = '0; fft_data[0] = 16'h7FFF;
    strobe();
    vx = 11'd10; vy = 11'd479;
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    repeat (4) cyc();
    #2 rst = 1'b1;
    cyc();
    chk("midrst_rgb", {8'h0, r_o, g_o, b_o}, 0);
    chk("midrst_busy", {busy, overrun}, 0);
    rst = 1'b0;
    model_reset();
    check_pix(10, 479, "midrst_cleared");
    frame(1'b0);
    check_pix(10, 479, "midrst_no_pending");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
